// File: rtl/transmit_port_scheduler_if.sv
// Ingress queue and egress transmit bundle for the transmit port scheduler.
// The master side feeds the ingress queues and drains tx; the slave side is the scheduler.
interface transmit_port_scheduler_if #(
    parameter int unsigned REQUESTERS = 4
);
    logic [REQUESTERS-1:0]       request;
    logic [REQUESTERS-1:0][8:0]  data;
    logic [REQUESTERS-1:0]       data_valid;
    logic [REQUESTERS-1:0]       ready;
    logic [8:0]                  tx_data;
    logic                        tx_valid;
    logic                        tx_ready;
    logic [REQUESTERS-1:0]       grant;
    logic                        busy;
    logic                        timeout_abort;

    modport master (
        output request, data, data_valid, tx_ready,
        input  ready, tx_data, tx_valid, grant, busy, timeout_abort
    );

    modport slave (
        input  request, data, data_valid, tx_ready,
        output ready, tx_data, tx_valid, grant, busy, timeout_abort
    );
endinterface

// File: rtl/transmit_port_scheduler.sv
// Frame-granular round-robin scheduler sharing one egress port among REQUESTERS queues,
// with inter-frame gap and runaway-frame truncation. Optional macro: SCHED_STRICT_PRIORITY_EN.
module transmit_port_scheduler #(
    parameter int unsigned REQUESTERS      = 4,
    parameter int unsigned IFG_CYCLES      = 12,
    parameter int unsigned MAX_FRAME_BYTES = 1522
) (
    input  logic                         clock,
    input  logic                         reset_n,
    transmit_port_scheduler_if.slave     bus
);
    localparam int unsigned IDX_W = $clog2(REQUESTERS);
    localparam int unsigned CNT_W = $clog2(MAX_FRAME_BYTES + 1);
    localparam int unsigned GAP_W = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_GAP} state_t;

    state_t                  state_q, state_d;
    logic [REQUESTERS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]        gidx_q, gidx_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [8:0]              tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    abort_q, abort_d;
    logic                    busy_q;

    logic                    hit_c;
    logic [IDX_W-1:0]        pick_c;
    logic                    g_ready_c;
    logic [REQUESTERS-1:0]   ready_c;
    logic [8:0]              g_data_c;
    logic                    g_valid_c;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int unsigned k);
        return IDX_W'((32'(base) + k) % REQUESTERS);
    endfunction

    assign g_data_c  = bus.data[gidx_q];
    assign g_valid_c = bus.data_valid[gidx_q];

    // Requester search, starting one past the last round-robin winner.
    always_comb begin : arbitrate
        hit_c  = 1'b0;
        pick_c = '0;
`ifdef SCHED_STRICT_PRIORITY_EN
        if (bus.request[0]) begin
            hit_c  = 1'b1;
            pick_c = '0;
        end else begin
            for (int unsigned k = 1; k <= REQUESTERS; k++) begin
                if (!hit_c && rr_idx(last_q, k) != '0 && bus.request[rr_idx(last_q, k)]) begin
                    hit_c  = 1'b1;
                    pick_c = rr_idx(last_q, k);
                end
            end
        end
`else
        for (int unsigned k = 1; k <= REQUESTERS; k++) begin
            if (!hit_c && bus.request[rr_idx(last_q, k)]) begin
                hit_c  = 1'b1;
                pick_c = rr_idx(last_q, k);
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin : state_reg
        if (!reset_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            last_q     <= IDX_W'(REQUESTERS - 1);
            cnt_q      <= '0;
            gap_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            abort_q    <= abort_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    always_comb begin : next_state
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        abort_d    = 1'b0;
        if (tx_valid_q && bus.tx_ready) tx_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hit_c) begin
                    state_d = S_STREAM;
                    grant_d = REQUESTERS'(1) << pick_c;
                    gidx_d  = pick_c;
`ifdef SCHED_STRICT_PRIORITY_EN
                    if (pick_c != '0) last_d = pick_c;
`else
                    last_d  = pick_c;
`endif
                end
            end
            S_STREAM: begin
                if (g_valid_c && g_ready_c) begin
                    tx_data_d  = g_data_c;
                    tx_valid_d = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (g_data_c[8]) begin
                        state_d = S_GAP;
                        cnt_d   = '0;
                    end else if (cnt_q + CNT_W'(1) == CNT_W'(MAX_FRAME_BYTES)) begin
                        // Runaway frame: close it on tx and swallow the remainder.
                        tx_data_d[8] = 1'b1;
                        abort_d      = 1'b1;
                        state_d      = S_FLUSH;
                        cnt_d        = '0;
                    end
                end
            end
            S_FLUSH: begin
                if (g_valid_c && g_data_c[8]) state_d = S_GAP;
            end
            S_GAP: begin
                if (!tx_valid_q) begin
                    if (gap_q == GAP_W'(IFG_CYCLES)) begin
                        state_d = S_IDLE;
                        grant_d = '0;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ingress accept: only the owner, and only while the output register can take a byte.
    always_comb begin : outputs
        ready_c   = '0;
        g_ready_c = 1'b0;
        case (state_q)
            S_STREAM: g_ready_c = !tx_valid_q || bus.tx_ready;
            S_FLUSH:  g_ready_c = 1'b1;
            default:  g_ready_c = 1'b0;
        endcase
        ready_c[gidx_q] = g_ready_c;
    end

    assign bus.ready         = ready_c;
    assign bus.tx_data       = tx_data_q;
    assign bus.tx_valid      = tx_valid_q;
    assign bus.grant         = grant_q;
    assign bus.busy          = busy_q;
    assign bus.timeout_abort = abort_q;

endmodule

// File: tb/tb_transmit_port_scheduler.sv
// Self-checking bench for transmit_port_scheduler: frame-level queue model with
// round-robin owner prediction, truncation rule, tx ordering and gap timing.
module tb_transmit_port_scheduler;
    localparam int unsigned R    = 4;
    localparam int          IFG  = 12;
    localparam int          MAXB = 8;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    transmit_port_scheduler_if #(.REQUESTERS(R)) bus ();

    transmit_port_scheduler #(
        .REQUESTERS      (R),
        .IFG_CYCLES      (IFG),
        .MAX_FRAME_BYTES (MAXB)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [8:0] bq [R][$];
    logic [8:0] exp_tx [$];
    int         gseq [$];
    int         own, last_model, exp_aborts, obs_aborts, tx_count, step_no, idle_run, exit_step;
    int         vpct, rmode;
    bit         seen_frame, in_frame, trunc_frame;
    logic [R-1:0] req_prev, grant_prev;
    logic       txv_prev, txr_prev, abort_prev, busy_prev;
    logic [8:0] txd_prev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [R-1:0] onehot(input int w);
        return (w < 0) ? '0 : (R'(1) << w);
    endfunction

    // Reference arbitration rule, evaluated on the request vector seen at the granting edge.
    function automatic int rr_pick(input logic [R-1:0] req, input int last, output int new_last);
        new_last = last;
`ifdef SCHED_STRICT_PRIORITY_EN
        if (req[0]) return 0;
        for (int k = 1; k <= int'(R); k++) begin
            int c;
            c = (last + k) % int'(R);
            if (c != 0 && ((req >> c) & R'(1)) != '0) begin
                new_last = c;
                return c;
            end
        end
`else
        for (int k = 1; k <= int'(R); k++) begin
            int c;
            c = (last + k) % int'(R);
            if (((req >> c) & R'(1)) != '0) begin
                new_last = c;
                return c;
            end
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(R); i++) bq[i].delete();
        exp_tx.delete();
        gseq.delete();
        own = -1; last_model = R - 1; exp_aborts = obs_aborts;
        req_prev = '0; grant_prev = '0; txv_prev = 1'b0; txr_prev = 1'b0;
        abort_prev = 1'b0; busy_prev = 1'b0; txd_prev = '0;
        in_frame = 0; seen_frame = 0; trunc_frame = 0; idle_run = 0; exit_step = -1;
    endtask

    task automatic add_frame(input int i, input int len);
        for (int k = 0; k < len; k++) bq[i].push_back({(k == len - 1), 8'($urandom)});
    endtask

    task automatic quiet_inputs();
        bus.request = '0; bus.data_valid = '0; bus.data = '0; bus.tx_ready = 1'b0;
    endtask

    // One clock: drive at negedge, check #1 later, let the posedge happen, return at next negedge.
    task automatic step();
        logic [R-1:0] rq, dv;
        logic [8:0]   b;
        int           w, nl, d;
        for (int i = 0; i < int'(R); i++) begin
            rq[i] = (bq[i].size() != 0);
            dv[i] = rq[i] && ($urandom_range(99) < vpct);
            bus.data[i] = dv[i] ? bq[i][0] : 9'($urandom);
        end
        bus.request = rq;
        bus.data_valid = dv;
        bus.tx_ready = (rmode == 1) ? 1'b1 : (rmode == 2) ? ((step_no % 2) == 0) : ($urandom_range(99) < 70);
        #1;
        if (grant_prev == '0 && bus.grant != '0) begin
            w = rr_pick(req_prev, last_model, nl);
            chk("grant_rr", 64'(bus.grant), 64'(onehot(w)));
            if (w >= 0) begin
                own = w; last_model = nl; gseq.push_back(w); trunc_frame = 0;
                for (int k = 0; k < bq[w].size(); k++) begin
                    b = bq[w][k];
                    if (k == MAXB - 1 && !b[8]) begin
                        b[8] = 1'b1;
                        exp_aborts++;
                    end
                    exp_tx.push_back(b);
                    if (b[8]) break;
                end
            end
        end else if (own >= 0 && bus.grant == '0) begin
            own = -1;
        end else begin
            chk("grant_hold", 64'(bus.grant), 64'(onehot(own)));
        end
        if (bus.timeout_abort) begin
            obs_aborts++;
            trunc_frame = 1;
            chk("abort_eof", 64'({bus.tx_valid, bus.tx_data[8], abort_prev}), 64'(3'b110));
        end
        chk("ready_owner", 64'(bus.ready & ~bus.grant), 64'(0));
        if (bus.tx_valid && !bus.tx_ready && !trunc_frame) chk("ready_bp", 64'(bus.ready), 64'(0));
        if (txv_prev && !txr_prev) chk("tx_hold", 64'({bus.tx_valid, bus.tx_data}), 64'({1'b1, txd_prev}));
        if (busy_prev && !bus.busy && !trunc_frame && exit_step >= 0) begin
            d = step_no - exit_step;
            chk("busy_fall_window", 64'(d >= IFG + 1 && d <= IFG + 3), 64'(1));
        end
        if (bus.tx_valid && bus.tx_ready) begin
            if (!in_frame) begin
                if (seen_frame) chk("ifg_idle", 64'(idle_run >= IFG + 1), 64'(1));
                in_frame = 1;
            end
            if (exp_tx.size() == 0) chk("tx_unexpected", 64'(exp_tx.size()), 64'(1));
            else chk("tx_byte", 64'(bus.tx_data), 64'(exp_tx.pop_front()));
            tx_count++;
            if (bus.tx_data[8]) begin
                in_frame = 0; seen_frame = 1; idle_run = 0; exit_step = step_no;
            end
        end else if (!bus.tx_valid && !in_frame) begin
            idle_run++;
        end
        for (int i = 0; i < int'(R); i++) if (dv[i] && bus.ready[i]) void'(bq[i].pop_front());
        req_prev = rq; grant_prev = bus.grant; txv_prev = bus.tx_valid; txr_prev = bus.tx_ready;
        txd_prev = bus.tx_data; abort_prev = bus.timeout_abort; busy_prev = bus.busy;
        step_no++;
        @(negedge clock);
    endtask

    task automatic drain(input int budget);
        int n;
        bit pend;
        n = 0;
        while (n < budget) begin
            pend = (exp_tx.size() != 0);
            for (int i = 0; i < int'(R); i++) pend |= (bq[i].size() != 0);
            if (!pend) break;
            step();
            n++;
        end
        chk("drain_in_budget", 64'(n < budget), 64'(1));
        for (int k = 0; k < IFG + 6; k++) step();
        chk("idle_after_drain", 64'(bus.busy), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, n;
        int rr_exp [6];
`ifdef SCHED_STRICT_PRIORITY_EN
        rr_exp = '{0, 0, 1, 2, 3, 1};
`else
        rr_exp = '{0, 1, 2, 3, 0, 1};
`endif
        obs_aborts = 0; step_no = 0; tx_count = 0; vpct = 100; rmode = 1;
        reset_n = 1'b0;
        quiet_inputs();
        model_reset();
        repeat (2) @(negedge clock);
        chk("reset_values", 64'({bus.ready, bus.tx_data, bus.tx_valid, bus.grant, bus.busy, bus.timeout_abort}), 64'(0));
        reset_n = 1'b1;
        @(negedge clock);

        // Single 4-byte frame from requester 0
        bq[0].push_back(9'h011); bq[0].push_back(9'h022);
        bq[0].push_back(9'h033); bq[0].push_back(9'h144);
        step();
        chk("grant_latency", 64'(bus.grant), 64'(4'b0001));
        drain(200);
        chk("single_tx_count", 64'(tx_count), 64'(4));

        // Backpressure: tx_ready toggles every cycle over a 6-byte frame
        rmode = 2; tx_count = 0;
        add_frame(1, 6);
        drain(300);
        chk("bp_tx_count", 64'(tx_count), 64'(6));

        // Truncation: 12-byte frame on requester 2 with limit 8, then requester 3
        rmode = 1; tx_count = 0; a0 = obs_aborts; gseq.delete();
        add_frame(2, 12);
        add_frame(3, 2);
        drain(300);
        chk("trunc_abort_once", 64'(obs_aborts - a0), 64'(1));
        chk("trunc_tx_count", 64'(tx_count), 64'(10));
        chk("trunc_first_grant", 64'(gseq[0]), 64'(2));
        chk("trunc_next_grant", 64'(gseq[1]), 64'(3));

        // Fairness: all four queues hold two 2-byte frames
        gseq.delete();
        for (int i = 0; i < int'(R); i++) begin
            add_frame(i, 2);
            add_frame(i, 2);
        end
        drain(600);
        for (int k = 0; k < 6; k++) chk("rr_sequence", 64'(gseq[k]), 64'(rr_exp[k]));

        // Randomized traffic: lengths around the truncation limit, random valid and backpressure
        rmode = 0; vpct = 70;
        for (int i = 0; i < int'(R); i++)
            for (int f = 0; f < 4; f++) add_frame(i, $urandom_range(1, 12));
        drain(6000);
        chk("abort_total", 64'(obs_aborts), 64'(exp_aborts));

        // Asynchronous reset after three bytes of a 10-byte frame
        rmode = 1; vpct = 100; tx_count = 0;
        add_frame(0, 10);
        n = 0;
        while (tx_count < 3 && n < 100) begin
            step();
            n++;
        end
        chk("pre_reset_bytes", 64'(tx_count), 64'(3));
        #2 reset_n = 1'b0;
        #1 chk("async_reset", 64'({bus.ready, bus.tx_data, bus.tx_valid, bus.grant, bus.busy, bus.timeout_abort}), 64'(0));
        quiet_inputs();
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        add_frame(1, 3);
        add_frame(2, 3);
        drain(300);
        chk("post_reset_first_grant", 64'(gseq[0]), 64'(1));
        chk("post_reset_second_grant", 64'(gseq[1]), 64'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
